// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage core.
// Mirrors EX/MEM/WB occupancy to produce load-use stalls, branch flushes and registered forwarding selects.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_RD_PORTS = 2,
  parameter int FWD_EN       = 1,
  parameter int CNT_W        = 16
) (
  input  logic                               clk,
  input  logic                               arst,
  input  logic                               enable,
  input  logic                               id_valid,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_RD_PORTS-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]              id_rd_addr,
  input  logic                               id_reg_write,
  input  logic                               id_mem_read,
  input  logic                               ex_branch_taken,
  output logic                               stall,
  output logic                               flush_if_id,
  output logic                               flush_id_ex,
  output logic [2*NUM_RD_PORTS-1:0]          fwd_sel,
  output logic                               ex_valid,
  output logic                               mem_valid,
  output logic                               wb_valid,
  output logic [CNT_W-1:0]                   stall_cnt,
  output logic [CNT_W-1:0]                   flush_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } ex_entry_t;

  ex_entry_t               ex_q;
  logic                    mem_valid_q;
  logic [REG_ADDR_W-1:0]   mem_rd_q;
  logic                    mem_rw_q;
  // WB matches never stall or forward (regfile bypass), so only occupancy is kept.
  logic                    wb_valid_q;
  logic [2*NUM_RD_PORTS-1:0] fwd_q;
  logic [2*NUM_RD_PORTS-1:0] fwd_next;
  logic [CNT_W-1:0]        stall_cnt_q;
  logic [CNT_W-1:0]        flush_cnt_q;
  logic                    hazard;
  logic                    flush;
  logic                    stall_int;
  logic [REG_ADDR_W-1:0]   rs;

  function automatic logic writes_reg(input logic v, input logic rw,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic [REG_ADDR_W-1:0] r);
    return v && rw && (rd == r) && (r != '0);
  endfunction

  always_comb begin
    hazard   = 1'b0;
    fwd_next = '0;
    rs       = '0;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      rs = id_rs_addr[k*REG_ADDR_W +: REG_ADDR_W];
      if (id_valid && id_rs_used[k]) begin
        if (FWD_EN != 0) begin
          if (writes_reg(ex_q.valid, ex_q.reg_write, ex_q.rd, rs) && ex_q.mem_read)
            hazard = 1'b1;
        end else if (writes_reg(ex_q.valid, ex_q.reg_write, ex_q.rd, rs) ||
                     writes_reg(mem_valid_q, mem_rw_q, mem_rd_q, rs)) begin
          hazard = 1'b1;
        end
      end
      if (FWD_EN != 0) begin
        if (writes_reg(ex_q.valid, ex_q.reg_write, ex_q.rd, rs))
          fwd_next[2*k +: 2] = 2'b01;
        else if (writes_reg(mem_valid_q, mem_rw_q, mem_rd_q, rs))
          fwd_next[2*k +: 2] = 2'b10;
      end
    end
    flush     = enable & ex_branch_taken;
    stall_int = enable & hazard & ~flush;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ex_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      fwd_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (enable) begin
      wb_valid_q  <= mem_valid_q;
      mem_valid_q <= ex_q.valid;
      mem_rd_q    <= ex_q.rd;
      mem_rw_q    <= ex_q.reg_write;
      if (stall_int || flush) begin
        ex_q  <= '0;
        fwd_q <= '0;
      end else begin
        ex_q  <= {id_valid, id_rd_addr, id_reg_write, id_mem_read};
        fwd_q <= id_valid ? fwd_next : '0;
      end
      if (stall_int && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall       = stall_int;
  assign flush_if_id = flush;
  assign flush_id_ex = flush;
  assign fwd_sel     = fwd_q;
  assign ex_valid    = ex_q.valid;
  assign mem_valid   = mem_valid_q;
  assign wb_valid    = wb_valid_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: a forwarding instance and a no-forwarding 4-bit-counter instance.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  logic arst;
  logic chk_tgl = 1'b0;
  always #5 clk = ~clk;

  logic       a_enable, a_id_valid, a_rw, a_mr, a_br;
  logic [9:0] a_rs;
  logic [1:0] a_used;
  logic [4:0] a_rd;
  logic       a_stall, a_fif, a_fie, a_exv, a_mv, a_wv;
  logic [3:0] a_fwd;
  logic [15:0] a_sc, a_fc;

  logic       b_enable, b_id_valid, b_rw, b_mr, b_br;
  logic [9:0] b_rs;
  logic [1:0] b_used;
  logic [4:0] b_rd;
  logic       b_stall, b_fif, b_fie, b_exv, b_mv, b_wv;
  logic [3:0] b_fwd;
  logic [3:0] b_sc, b_fc;

  hazard_ctrl_unit dut (
    .clk(clk), .arst(arst), .enable(a_enable), .id_valid(a_id_valid),
    .id_rs_addr(a_rs), .id_rs_used(a_used), .id_rd_addr(a_rd),
    .id_reg_write(a_rw), .id_mem_read(a_mr), .ex_branch_taken(a_br),
    .stall(a_stall), .flush_if_id(a_fif), .flush_id_ex(a_fie), .fwd_sel(a_fwd),
    .ex_valid(a_exv), .mem_valid(a_mv), .wb_valid(a_wv),
    .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  hazard_ctrl_unit #(.FWD_EN(0), .CNT_W(4)) dut0 (
    .clk(clk), .arst(arst), .enable(b_enable), .id_valid(b_id_valid),
    .id_rs_addr(b_rs), .id_rs_used(b_used), .id_rd_addr(b_rd),
    .id_reg_write(b_rw), .id_mem_read(b_mr), .ex_branch_taken(b_br),
    .stall(b_stall), .flush_if_id(b_fif), .flush_id_ex(b_fie), .fwd_sel(b_fwd),
    .ex_valid(b_exv), .mem_valid(b_mv), .wb_valid(b_wv),
    .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  localparam int MS = 1, MF = 2, ME = 4, MW = 8, MC = 16, MD = 32, MV = 64, MB = 128;

  typedef struct {
    string nm;
    int    inst;
    int    mask;
    bit    st, fl, exv;
    int    fwd, sc, fc;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int checks = 0;
  int failures = 0;

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, exp);
    end
  endtask

  // Monitor: drains every pending expectation at the sampling point.
  initial forever begin
    @(negedge clk or chk_tgl);
    while (q.size() > 0) begin
      int st, fi, fe, ev, mv, wv, fw, sc, fc;
      e_m = q.pop_front();
      if (e_m.inst == 0) begin
        st = int'(a_stall); fi = int'(a_fif); fe = int'(a_fie); ev = int'(a_exv);
        mv = int'(a_mv); wv = int'(a_wv); fw = int'(a_fwd); sc = int'(a_sc); fc = int'(a_fc);
      end else begin
        st = int'(b_stall); fi = int'(b_fif); fe = int'(b_fie); ev = int'(b_exv);
        mv = int'(b_mv); wv = int'(b_wv); fw = int'(b_fwd); sc = int'(b_sc); fc = int'(b_fc);
      end
      if ((e_m.mask & MS) != 0) cmp(e_m.nm, "stall", st, int'(e_m.st));
      if ((e_m.mask & MF) != 0) begin
        cmp(e_m.nm, "flush_if_id", fi, int'(e_m.fl));
        cmp(e_m.nm, "flush_id_ex", fe, int'(e_m.fl));
      end
      if ((e_m.mask & ME) != 0) cmp(e_m.nm, "ex_valid", ev, int'(e_m.exv));
      if ((e_m.mask & MW) != 0) cmp(e_m.nm, "fwd_sel", fw, e_m.fwd);
      if ((e_m.mask & MC) != 0) cmp(e_m.nm, "stall_cnt", sc, e_m.sc);
      if ((e_m.mask & MD) != 0) cmp(e_m.nm, "flush_cnt", fc, e_m.fc);
      if ((e_m.mask & MV) != 0) cmp(e_m.nm, "mem_valid", mv, 0);
      if ((e_m.mask & MB) != 0) cmp(e_m.nm, "wb_valid", wv, 0);
    end
  end

  task automatic push_exp(input int inst, input string nm, input int mask,
                          input bit st, input bit fl, input bit exv,
                          input int fwd, input int sc, input int fc);
    exp_t e;
    e.nm = nm; e.inst = inst; e.mask = mask;
    e.st = st; e.fl = fl; e.exv = exv; e.fwd = fwd; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic vec(input int inst, input string nm, input bit en, input bit idv,
                     input int rs0, input int rs1, input int used, input int rd,
                     input bit rw, input bit mr, input bit br, input int mask,
                     input bit st, input bit fl, input bit exv,
                     input int fwd, input int sc, input int fc);
    @(posedge clk);
    #1;
    if (inst == 0) begin
      a_enable = en; a_id_valid = idv; a_rs = {5'(rs1), 5'(rs0)}; a_used = 2'(used);
      a_rd = 5'(rd); a_rw = rw; a_mr = mr; a_br = br;
    end else begin
      b_enable = en; b_id_valid = idv; b_rs = {5'(rs1), 5'(rs0)}; b_used = 2'(used);
      b_rd = 5'(rd); b_rw = rw; b_mr = mr; b_br = br;
    end
    push_exp(inst, nm, mask, st, fl, exv, fwd, sc, fc);
  endtask

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    a_enable = 1'b1; a_id_valid = 1'b0; a_rs = '0; a_used = '0; a_rd = '0;
    a_rw = 1'b0; a_mr = 1'b0; a_br = 1'b0;
    b_enable = 1'b1; b_id_valid = 1'b0; b_rs = '0; b_used = '0; b_rd = '0;
    b_rw = 1'b0; b_mr = 1'b0; b_br = 1'b0;
    #2;
    push_exp(0, "reset_a", 255, 0, 0, 0, 0, 0, 0);
    push_exp(1, "reset_b", 255, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 arst = 1'b0;

    // forwarding distances 1, 2, 3
    vec(0, "add5",     1, 1, 1, 2, 3, 5, 1, 0, 0, 63,      0, 0, 0, 0, 0, 0);
    vec(0, "dep1",     1, 1, 5, 1, 3, 6, 1, 0, 0, MS|ME|MW, 0, 0, 1, 0, 0, 0);
    vec(0, "fwd_d1",   1, 0, 0, 0, 0, 0, 0, 0, 0, MS|ME|MW, 0, 0, 1, 4'b0001, 0, 0);
    vec(0, "add5b",    1, 1, 0, 0, 0, 5, 1, 0, 0, ME|MW,    0, 0, 0, 0, 0, 0);
    vec(0, "gap_a",    1, 0, 0, 0, 0, 0, 0, 0, 0, ME,       0, 0, 1, 0, 0, 0);
    vec(0, "dep2",     1, 1, 5, 1, 3, 6, 1, 0, 0, MS|ME,    0, 0, 0, 0, 0, 0);
    vec(0, "fwd_d2",   1, 0, 0, 0, 0, 0, 0, 0, 0, ME|MW,    0, 0, 1, 4'b0010, 0, 0);
    vec(0, "add5c",    1, 1, 0, 0, 0, 5, 1, 0, 0, MS,       0, 0, 0, 0, 0, 0);
    vec(0, "gap_b",    1, 0, 0, 0, 0, 0, 0, 0, 0, ME,       0, 0, 1, 0, 0, 0);
    vec(0, "gap_c",    1, 0, 0, 0, 0, 0, 0, 0, 0, ME,       0, 0, 0, 0, 0, 0);
    vec(0, "dep3",     1, 1, 5, 1, 3, 6, 1, 0, 0, MS,       0, 0, 0, 0, 0, 0);
    vec(0, "fwd_d3",   1, 0, 0, 0, 0, 0, 0, 0, 0, ME|MW,    0, 0, 1, 0, 0, 0);
    // load-use: one stall, then MEM/WB forwarding on both ports
    vec(0, "ld5",      1, 1, 1, 0, 1, 5, 1, 1, 0, MS,       0, 0, 0, 0, 0, 0);
    vec(0, "lu_stall", 1, 1, 5, 5, 3, 6, 1, 0, 0, MS|MF|ME|MC, 1, 0, 1, 0, 0, 0);
    vec(0, "lu_bub",   1, 1, 5, 5, 3, 6, 1, 0, 0, MS|ME|MW|MC, 0, 0, 0, 0, 1, 0);
    vec(0, "lu_fwd",   1, 0, 0, 0, 0, 0, 0, 0, 0, MS|ME|MW|MC, 0, 0, 1, 4'b1010, 1, 0);
    // x0 never matches
    vec(0, "ld0",      1, 1, 1, 0, 1, 0, 1, 1, 0, MS,       0, 0, 0, 0, 0, 0);
    vec(0, "x0_use",   1, 1, 0, 0, 3, 7, 1, 0, 0, MS|MC,    0, 0, 0, 0, 1, 0);
    vec(0, "x0_fwd",   1, 0, 0, 0, 0, 0, 0, 0, 0, ME|MW,    0, 0, 1, 0, 0, 0);
    // branch taken in the same cycle as a load-use
    vec(0, "ld5b",     1, 1, 1, 0, 1, 5, 1, 1, 0, MS,       0, 0, 0, 0, 0, 0);
    vec(0, "br_lu",    1, 1, 5, 5, 3, 6, 1, 0, 1, MS|MF|MC|MD, 0, 1, 0, 0, 1, 0);
    vec(0, "br_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, MS|MF|ME|MC|MD, 0, 0, 0, 0, 1, 1);
    // enable low forces stall/flush to 0 and freezes state
    vec(0, "ld5c",     1, 1, 1, 0, 1, 5, 1, 1, 0, MS,       0, 0, 0, 0, 0, 0);
    vec(0, "en0",      0, 1, 5, 5, 3, 6, 1, 0, 1, MS|MF|ME|MC|MD, 0, 0, 1, 0, 1, 1);
    vec(0, "en0_hold", 1, 1, 5, 5, 3, 6, 1, 0, 0, MS|ME|MC|MD, 1, 0, 1, 0, 1, 1);
    vec(0, "en_bub",   1, 1, 5, 5, 3, 6, 1, 0, 0, MS|ME|MC, 0, 0, 0, 0, 2, 0);
    // build stall_cnt=3 with an active stall, then reset asynchronously
    vec(0, "ld5d",     1, 1, 1, 0, 1, 5, 1, 1, 0, MS,       0, 0, 0, 0, 0, 0);
    vec(0, "lu2",      1, 1, 5, 5, 3, 6, 1, 0, 0, MS|MC,    1, 0, 0, 0, 2, 0);
    vec(0, "ld5e",     1, 1, 1, 0, 1, 5, 1, 1, 0, MS|MC,    0, 0, 0, 0, 3, 0);
    vec(0, "lu3",      1, 1, 5, 5, 3, 6, 1, 0, 0, MS|ME|MC, 1, 0, 1, 0, 3, 0);
    @(negedge clk);
    #1 arst = 1'b1;
    #1;
    push_exp(0, "rst_async", 255, 0, 0, 0, 0, 0, 0);
    chk_tgl = ~chk_tgl;
    #1;
    arst = 1'b0;
    a_id_valid = 1'b0; a_used = '0;

    // no forwarding, 4-bit counter: distance-1 chain saturates stall_cnt
    vec(1, "chain0", 1, 1, 0, 0, 1, 1, 1, 0, 0, MS|MC, 0, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 10; j++) begin
      vec(1, "chain_a", 1, 1, j, 0, 1, j + 1, 1, 0, 0, MS|ME|MW|MC, 1, 0, 1, 0, sat15(2*(j-1)), 0);
      vec(1, "chain_b", 1, 1, j, 0, 1, j + 1, 1, 0, 0, MS|ME|MC,    1, 0, 0, 0, sat15(2*j-1), 0);
      vec(1, "chain_c", 1, 1, j, 0, 1, j + 1, 1, 0, 0, MS|ME|MW|MC, 0, 0, 0, 0, sat15(2*j), 0);
    end
    vec(1, "unused_src", 1, 1, 11, 0, 0, 20, 1, 0, 0, MS|ME|MC, 0, 0, 1, 0, 15, 0);
    vec(1, "dist2_stl",  1, 1, 11, 0, 1, 21, 1, 0, 0, MS|ME|MC, 1, 0, 1, 0, 15, 0);
    vec(1, "dist2_go",   1, 1, 11, 0, 1, 21, 1, 0, 0, MS|ME|MC, 0, 0, 0, 0, 15, 0);
    vec(1, "nofwd_sel",  1, 0, 0, 0, 0, 0, 0, 0, 0, ME|MW|MC,  0, 0, 1, 0, 15, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
